// File: rtl/mac_result_accumulator_if.sv
// Valid/ready bundle between the mac result stream, the accumulator and the next stage.
// master drives beats and out_ready; slave is the accumulator view.
interface mac_result_accumulator_if #(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int LEN_WIDTH = 5
);
  logic [IN_WIDTH-1:0]  in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [LEN_WIDTH-1:0] cfg_len;
  logic [ACC_WIDTH-1:0] out_sum;
  logic                 out_ovf;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_data, in_valid, cfg_len, out_ready,
    input  in_ready, out_sum, out_ovf, out_valid
  );

  modport slave (
    input  in_data, in_valid, cfg_len, out_ready,
    output in_ready, out_sum, out_ovf, out_valid
  );
endinterface

// File: rtl/mac_result_accumulator.sv
// Sums cfg_len mac results into one saturating total; out_valid rises on the edge taking the last beat.
// Backpressure: while a total is held, in_ready follows out_ready so handoff and next vector start share a cycle.
module mac_result_accumulator #(
  parameter int IN_WIDTH  = 8,
  parameter int ACC_WIDTH = 16,
  parameter int LEN_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          reset,
  mac_result_accumulator_if.slave       bus
);
  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic                 ovf;
  logic [LEN_WIDTH-1:0] cnt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [ACC_WIDTH-1:0] out_sum_q;
  logic                 out_ovf_q;
  logic                 out_valid_q;

  logic                 in_fire;
  logic [ACC_WIDTH:0]   ext;
  logic [ACC_WIDTH:0]   sum_wide;
  logic [ACC_WIDTH-1:0] nxt_acc;
  logic                 nxt_ovf;
  logic [LEN_WIDTH-1:0] nxt_cnt;
  logic [LEN_WIDTH-1:0] nxt_len;
  logic                 nxt_last;

  assign bus.in_ready  = reset & ((state != HOLD) | bus.out_ready);
  assign in_fire       = bus.in_valid & bus.in_ready;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_ovf   = out_ovf_q;
  assign bus.out_valid = out_valid_q;

  // Any beat accepted outside ACCUM opens a new vector (IDLE, or HOLD during handoff).
  always_comb begin
    ext                 = '0;
    ext[IN_WIDTH-1:0]   = bus.in_data;
    sum_wide            = {1'b0, acc} + ext;
    nxt_acc             = ext[ACC_WIDTH-1:0];
    nxt_ovf             = 1'b0;
    nxt_cnt             = LEN_WIDTH'(1);
    nxt_len             = (bus.cfg_len == '0) ? LEN_WIDTH'(1) : bus.cfg_len;
    if (state == ACCUM) begin
      nxt_acc = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
      nxt_ovf = ovf | sum_wide[ACC_WIDTH];
      nxt_cnt = cnt + LEN_WIDTH'(1);
      nxt_len = len_q;
    end
    nxt_last = (nxt_cnt == nxt_len);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      acc         <= '0;
      ovf         <= 1'b0;
      cnt         <= '0;
      len_q       <= '0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (in_fire) begin
      acc         <= nxt_acc;
      ovf         <= nxt_ovf;
      cnt         <= nxt_cnt;
      len_q       <= nxt_len;
      out_valid_q <= nxt_last;
      if (nxt_last) begin
        state     <= HOLD;
        out_sum_q <= nxt_acc;
        out_ovf_q <= nxt_ovf;
      end else begin
        state     <= ACCUM;
      end
    end else if (state == HOLD && bus.out_ready) begin
      state       <= IDLE;
      out_valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mac_result_accumulator.sv
module tb_mac_result_accumulator;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic [4:0] cfg_len;
  logic       out_ready;

  always #5 clk = ~clk;

  mac_result_accumulator_if #(.IN_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(5)) b16 ();
  mac_result_accumulator_if #(.IN_WIDTH(8), .ACC_WIDTH(9),  .LEN_WIDTH(5)) b9 ();

  assign b16.in_data   = in_data;
  assign b16.in_valid  = in_valid;
  assign b16.cfg_len   = cfg_len;
  assign b16.out_ready = out_ready;
  assign b9.in_data    = in_data;
  assign b9.in_valid   = in_valid;
  assign b9.cfg_len    = cfg_len;
  assign b9.out_ready  = out_ready;

  mac_result_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(16), .LEN_WIDTH(5)) dut16 (
    .clk(clk), .reset(reset), .bus(b16)
  );
  mac_result_accumulator #(.IN_WIDTH(8), .ACC_WIDTH(9), .LEN_WIDTH(5)) dut9 (
    .clk(clk), .reset(reset), .bus(b9)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic [4:0]  len;
    int          nb;
    logic [63:0] d;    // beat i in bits [8*i +: 8]
    logic [15:0] s16;
    logic [8:0]  s9;
    logic        o16;
    logic        o9;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Presents one beat, waits (bounded) for acceptance, returns at the following negedge.
  task automatic beat(input logic [7:0] d, input logic [4:0] len);
    int w;
    w = 0;
    in_valid = 1'b1;
    in_data  = d;
    cfg_len  = len;
    #1;
    while (!(b16.in_ready && b9.in_ready) && w < 50) begin
      @(negedge clk);
      #1;
      w++;
    end
    if (w >= 50) chk("beat_accept_timeout", 32'(w), 32'(0));
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain(input string name, input logic [15:0] s16, input logic [8:0] s9,
                       input logic o16, input logic o9);
    chk({name, "_vld16"}, 32'(b16.out_valid), 32'(1));
    chk({name, "_vld9"},  32'(b9.out_valid),  32'(1));
    chk({name, "_sum16"}, 32'(b16.out_sum),   32'(s16));
    chk({name, "_sum9"},  32'(b9.out_sum),    32'(s9));
    chk({name, "_ovf16"}, 32'(b16.out_ovf),   32'(o16));
    chk({name, "_ovf9"},  32'(b9.out_ovf),    32'(o9));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({name, "_idle16"}, 32'(b16.out_valid), 32'(0));
    chk({name, "_idle9"},  32'(b9.out_valid),  32'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  rem;
    bit  pend;
    int  tot [2];
    int  vo  [2];
    int  res [2];
    int  ro  [2];
    int  mx  [2];
    bit  exp_rdy;

    tbl[0] = '{5'd4, 4, 64'h00000000_F07A4316, 16'h01C3, 9'h1C3, 1'b0, 1'b0};
    tbl[1] = '{5'd3, 3, 64'h00000000_00F0F0F0, 16'h02D0, 9'h1FF, 1'b0, 1'b1};
    tbl[2] = '{5'd3, 3, 64'h00000000_0001FFFF, 16'h01FF, 9'h1FF, 1'b0, 1'b0};
    tbl[3] = '{5'd1, 1, 64'h00000000_000000F0, 16'h00F0, 9'h0F0, 1'b0, 1'b0};
    tbl[4] = '{5'd0, 1, 64'h00000000_00000005, 16'h0005, 9'h005, 1'b0, 1'b0};
    tbl[5] = '{5'd5, 5, 64'h000000FF_FFFFFFFF, 16'h04FB, 9'h1FF, 1'b0, 1'b1};
    tbl[6] = '{5'd4, 4, 64'h00000000_0010FFFF, 16'h020E, 9'h1FF, 1'b0, 1'b1};
    tbl[7] = '{5'd8, 8, 64'h01020304_05060708, 16'h0024, 9'h024, 1'b0, 1'b0};

    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'h00;
    cfg_len   = 5'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_in_ready16", 32'(b16.in_ready),  32'(0));
    chk("rst_in_ready9",  32'(b9.in_ready),   32'(0));
    chk("rst_out_valid",  32'(b16.out_valid), 32'(0));
    chk("rst_out_sum",    32'(b16.out_sum),   32'(0));
    chk("rst_out_ovf",    32'(b16.out_ovf),   32'(0));
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("idle_in_ready", 32'(b16.in_ready), 32'(1));
    @(negedge clk);

    // Table vectors; cfg_len is scrambled after the first beat and must be ignored.
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < tbl[i].nb; j++)
        beat(tbl[i].d[8*j +: 8], (j == 0) ? tbl[i].len : 5'($urandom));
      drain($sformatf("tbl%0d", i), tbl[i].s16, tbl[i].s9, tbl[i].o16, tbl[i].o9);
    end

    // Gapped input with cfg_len changed between beats.
    beat(8'h01, 5'd3);
    cfg_len = 5'd1;
    @(negedge clk);
    chk("gap_no_out1", 32'(b16.out_valid), 32'(0));
    beat(8'h02, 5'd1);
    @(negedge clk);
    chk("gap_no_out2", 32'(b16.out_valid), 32'(0));
    beat(8'h03, 5'd9);
    drain("gap", 16'h0006, 9'h006, 1'b0, 1'b0);

    // Backpressure: total held stable, then handoff and new vector in the same cycle.
    beat(8'h10, 5'd2);
    beat(8'h20, 5'd2);
    in_valid = 1'b1;
    in_data  = 8'h05;
    cfg_len  = 5'd1;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_in_ready", 32'(b16.in_ready), 32'(0));
      chk("bp_vld",      32'(b16.out_valid), 32'(1));
      chk("bp_sum",      32'(b16.out_sum), 32'h30);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_rdy", 32'(b16.in_ready), 32'(1));
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drain("bp_next", 16'h0005, 9'h005, 1'b0, 1'b0);

    // Reset mid-vector discards the partial total.
    beat(8'h16, 5'd4);
    beat(8'h43, 5'd4);
    in_valid = 1'b1;
    reset    = 1'b0;
    #1;
    chk("midrst_vld",   32'(b16.out_valid), 32'(0));
    chk("midrst_rdy16", 32'(b16.in_ready),  32'(0));
    chk("midrst_rdy9",  32'(b9.in_ready),   32'(0));
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    beat(8'h7A, 5'd1);
    drain("midrst_next", 16'h007A, 9'h07A, 1'b0, 1'b0);

    // Randomized traffic against a vector-level model.
    rem  = 0;
    pend = 1'b0;
    mx   = '{65535, 511};
    tot  = '{0, 0};
    vo   = '{0, 0};
    res  = '{0, 0};
    ro   = '{0, 0};
    repeat (3000) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      cfg_len   = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(4));
      out_ready = ($urandom_range(2) != 0);
      #1;
      exp_rdy = !pend || out_ready;
      chk("rnd_in_ready16", 32'(b16.in_ready), 32'(exp_rdy));
      chk("rnd_in_ready9",  32'(b9.in_ready),  32'(exp_rdy));
      chk("rnd_vld",        32'(b16.out_valid), 32'(pend));
      if (pend) begin
        chk("rnd_sum16", 32'(b16.out_sum), 32'(res[0]));
        chk("rnd_sum9",  32'(b9.out_sum),  32'(res[1]));
        chk("rnd_ovf16", 32'(b16.out_ovf), 32'(ro[0]));
        chk("rnd_ovf9",  32'(b9.out_ovf),  32'(ro[1]));
      end
      if (pend && out_ready) pend = 1'b0;
      if (in_valid && exp_rdy) begin
        if (rem == 0) begin
          rem = (cfg_len == 0) ? 1 : int'(cfg_len);
          tot = '{0, 0};
          vo  = '{0, 0};
        end
        for (int k = 0; k < 2; k++) begin
          if (tot[k] + int'(in_data) > mx[k]) begin
            tot[k] = mx[k];
            vo[k]  = 1;
          end else begin
            tot[k] = tot[k] + int'(in_data);
          end
        end
        rem--;
        if (rem == 0) begin
          pend = 1'b1;
          res  = tot;
          ro   = vo;
        end
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_result_accumulator.md
Name: mac_result_accumulator

Overview:
Downstream consumer of the mac stage's 8-bit result stream. It sums a configurable number of consecutive mac results into one wider dot-product total, saturating on overflow. It presents each total on a valid/ready output port for the next stage. Both sides use valid/ready handshakes so the block can absorb backpressure from the next stage.

Parameters:
IN_WIDTH, 8, width of each incoming mac result; matches the mac OUT_WIDTH.
ACC_WIDTH, 16, accumulator and output sum width; must be greater than or equal to IN_WIDTH.
LEN_WIDTH, 5, width of the vector-length config input; vector lengths are 1..2^LEN_WIDTH-1.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low reset; 0 resets the block immediately, 1 means run.
in_data  input  IN_WIDTH  mac result, unsigned.
in_valid  input  1  in_data is valid this cycle.
in_ready  output  1  block accepts in_data this cycle; a beat transfers when in_valid and in_ready are both 1.
cfg_len  input  LEN_WIDTH  number of beats per vector; sampled only on the first beat of a vector.
out_sum  output  ACC_WIDTH  accumulated vector total.
out_ovf  output  1  total saturated during this vector.
out_valid  output  1  out_sum and out_ovf are valid.
out_ready  input  1  downstream accepts the output; handoff occurs when out_valid and out_ready are both 1.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; acc, cnt, len_q, out_sum, out_ovf and out_valid all 0.
  - in_ready is forced to 0 while reset=0.
- States: IDLE, ACCUM, HOLD.
- in_ready (combinational) = reset & (state!=HOLD | out_ready).
- First beat (accepted in IDLE, or in HOLD with out_ready=1):
  - len_q = cfg_len, with cfg_len=0 treated as 1.
  - acc = zero-extended in_data; ovf = 0; cnt = 1.
  - Next state is HOLD if len_q==1, else ACCUM.
- ACCUM:
  - Each accepted beat computes acc + zero-extended in_data in ACC_WIDTH+1 bits.
  - If the carry is set: acc = all-ones and ovf = 1 (sticky); otherwise acc = the sum.
  - cnt increments on each accepted beat.
  - When the accepted beat makes cnt==len_q, next state is HOLD.
  - Cycles with in_valid=0 change nothing. cfg_len changes mid-vector are ignored.
- HOLD:
  - out_valid=1, out_sum=acc, out_ovf=ovf, all registered.
  - Outputs stay stable until handoff, whatever in_valid does.
  - On out_ready=1: handoff occurs. If in_valid=1 in the same cycle, that beat starts a new vector with no bubble; otherwise next state is IDLE and out_valid drops next cycle.
- Latency: out_valid rises on the clock edge that accepts the last beat, so it is visible the cycle after that beat is presented. Throughput is one beat per cycle.
- Saturation boundary: a sum exactly equal to 2^ACC_WIDTH-1 does not set ovf.
- Reset mid-vector: the partial total is discarded with no output. The first beat after release starts a fresh vector.
- out_ready is ignored outside HOLD.

Test Plan:
- Basic sum: cfg_len=4; beats 0x16, 0x43, 0x7A, 0xF0 with in_valid held high → one cycle later out_valid=1, out_sum=0x01C3, out_ovf=0; state returns to IDLE after out_ready.
- Saturation: ACC_WIDTH=9, cfg_len=3; beats 0xF0 x3 → out_sum=0x1FF, out_ovf=1. Separately, beats 0xFF, 0xFF, 0x01 → out_sum=0x1FF, out_ovf=0.
- Backpressure: after a cfg_len=2 vector of 0x10, 0x20, hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 throughout and out_sum=0x0030 stable. Then raise out_ready with the next beat present → handoff and new vector start in the same cycle, no bubble.
- Length edge cases: cfg_len=1 with beat 0xF0 → out_sum=0x00F0 on the next cycle. cfg_len=0 with beat 0x05 → behaves as length 1. Changing cfg_len mid-vector → no effect on the current vector.
- Reset mid-vector: cfg_len=4, accept 0x16 and 0x43, then pulse reset=0 → out_valid=0 and in_ready=0 during reset. Next vector cfg_len=1 with beat 0x7A → out_sum=0x007A.
- Gapped input: cfg_len=3 with in_valid toggling 1,0,1,0,1 carrying 0x01, 0x02, 0x03 → out_sum=0x0006; idle cycles do not advance cnt.
